servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
- Downstream stage of the ServoControl AXI4-Lite register slave.
- Consumes the register-file values (enable, period, per-channel pulse widths, slew step) and generates NUM_CH hobby-servo PWM outputs.
- Register updates are staged and applied atomically at frame boundaries, so software writes never produce glitched pulses.
- Optional slew limiting moves each channel's pulse width toward its target by at most a programmed step per frame.

Parameters:
NUM_CH, 4, number of servo channels
CNT_W, 16, width of all microsecond quantities
PRESCALE, 100, ACLK cycles per 1 us tick (100 MHz ACLK)
MIN_US, 500, minimum pulse width in us; narrower requests are clamped up
MAX_US, 2500, maximum pulse width in us; wider requests are clamped down
DEF_US, 1500, reset pulse width and reset target, in us
DEF_PERIOD_US, 20000, reset frame period in us

Ports:
ACLK  in  1  clock, rising edge
ARESETN  in  1  asynchronous active-low reset
cfg_load  in  1  one-cycle strobe from the register slave after any config register write
cfg_enable  in  NUM_CH  per-channel output enable
cfg_period_us  in  CNT_W  frame period in us
cfg_width_us  in  NUM_CH*CNT_W  target widths; channel i occupies [i*CNT_W +: CNT_W]
cfg_step_us  in  CNT_W  maximum width change per frame; 0 means no slew limit
cfg_pending  out  1  staged config is waiting for the next frame boundary
pwm_out  out  NUM_CH  servo PWM outputs, registered
frame_tick  out  1  one-cycle pulse on the first cycle of each frame
cur_width_us  out  NUM_CH*CNT_W  currently applied widths, for readback

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - pwm_out=0, frame_tick=0, cfg_pending=0, prescaler=0, us_cnt=0.
  - Active enables=0; active period=DEF_PERIOD_US; cur and target widths=DEF_US; staging regs equal the active values.
- Prescaler: counts 0..PRESCALE-1; us_tick=1 in the cycle where the count is PRESCALE-1, then wraps to 0.
- Frame counter us_cnt:
  - Advances on us_tick.
  - Boundary cycle B: us_tick=1 and us_cnt==period_act-1.
  - In cycle B+1: us_cnt=0, frame_tick=1, and newly applied config is active.
- Staging on cfg_load:
  - Next edge captures enable, step, period and clamped widths into the staging regs; cfg_pending<=1.
  - Width clamp: w<MIN_US gives MIN_US; w>MAX_US gives MAX_US.
  - Period clamp: period<MAX_US+1 gives MAX_US+1, so 0 is legal and clamped.
  - A later cfg_load before the boundary overwrites the staging regs (last write wins).
- Apply at boundary B, only when cfg_pending=1:
  - Staging regs are copied to the active enables, period, step and target widths.
  - cfg_pending<=0.
  - If cfg_load is also asserted in cycle B: the old staging contents are applied, the new values are captured into staging, and cfg_pending stays 1.
- Slew, evaluated at every boundary after the apply step, using the post-apply target and step, for each channel independently:
  - step==0, or |target-cur|<=step: cur<=target.
  - Otherwise cur<=cur+step or cur-step, toward target.
  - Arithmetic is unsigned CNT_W, compared before subtracting; no wrap-around.
  - Slew continues while a channel is disabled.
- Output generation:
  - pwm_out[i] is registered: pwm_out[i] <= enable_act[i] && (us_cnt < cur[i]).
  - This gives one ACLK of latency relative to us_cnt.
  - High time = cur[i] us; frame length = period_act*PRESCALE cycles.
- Enable and disable take effect only at a boundary, so no runt pulses occur.
- cur_width_us: mirrors the cur registers directly.
- Reset mid-frame: all outputs go low immediately; the first frame_tick occurs one full default frame after reset release.

Test Plan:
- Reset defaults (PRESCALE=4): release reset with no cfg_load -> pwm_out stays 0; frame_tick every 80000 cycles; cur_width_us reads 1500 for all channels; cfg_pending=0.
- Basic PWM: cfg_load with enable=4'b0101, period=3000, widths {1000,2000,1500,500}, step=0 -> at the next boundary cfg_pending falls. Following frames:
  - ch0 is high 4000 cycles and ch2 is high 6000 cycles of each 12000-cycle frame.
  - ch1 and ch3 stay low.
- Clamping: widths {100,3000,2500,500}, period=0 -> cur_width_us reads {500,2500,2500,500}; period becomes 2501 us.
- Slew limiting: cur=1500, target=2000, step=200 -> cur reads 1700, 1900, 2000, 2000 after successive frame_ticks. A target of 1000 from 2000 reaches 1000 after 5 frames.
- Simultaneous load and boundary: cfg_load A mid-frame, then cfg_load B exactly in cycle B -> A is applied at this boundary, cfg_pending stays 1, B is applied at the next boundary. Also two loads in one frame -> only the last one is applied.
- Reset mid-frame: assert ARESETN low while pwm_out=1 -> pwm_out=0 asynchronously. After release, all state matches the reset-defaults scenario and staged config is discarded.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Multi-channel hobby-servo PWM generator. Configuration from the register
// slave is staged on cfg_load and applied atomically at frame boundaries;
// applied widths optionally slew toward their targets by a bounded step.
module servo_pwm_gen #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PRESCALE      = 100,
  parameter int unsigned MIN_US        = 500,
  parameter int unsigned MAX_US        = 2500,
  parameter int unsigned DEF_US        = 1500,
  parameter int unsigned DEF_PERIOD_US = 20000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       cfg_enable,
  input  logic [CNT_W-1:0]        cfg_period_us,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width_us,
  input  logic [CNT_W-1:0]        cfg_step_us,
  output logic                    cfg_pending,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_tick,
  output logic [NUM_CH*CNT_W-1:0] cur_width_us
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(MAX_US + 1);
  localparam logic [CNT_W-1:0] DEF_W   = CNT_W'(DEF_US);
  localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(DEF_PERIOD_US);

  // Timebase
  logic [PS_W-1:0]   r_presc;
  logic [CNT_W-1:0]  r_us_cnt;
  logic              r_frame_tick;
  // Staged configuration
  logic              r_pending;
  logic [NUM_CH-1:0] r_en_stg;
  logic [CNT_W-1:0]  r_period_stg;
  logic [CNT_W-1:0]  r_step_stg;
  logic [CNT_W-1:0]  r_width_stg [NUM_CH];
  // Active configuration and slewed widths
  logic [NUM_CH-1:0] r_en_act;
  logic [CNT_W-1:0]  r_period_act;
  logic [CNT_W-1:0]  r_step_act;
  logic [CNT_W-1:0]  r_tgt [NUM_CH];
  logic [CNT_W-1:0]  r_cur [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  logic              w_us_tick;
  logic              w_boundary;
  logic              w_apply;
  logic [CNT_W-1:0]  w_period_clamped;
  logic [CNT_W-1:0]  w_width_clamped [NUM_CH];
  logic [CNT_W-1:0]  w_step_next;
  logic [CNT_W-1:0]  w_tgt_next [NUM_CH];
  logic [CNT_W-1:0]  w_cur_next [NUM_CH];

  assign w_us_tick  = (r_presc == PS_LAST);
  assign w_boundary = w_us_tick && (r_us_cnt == r_period_act - CNT_W'(1));
  assign w_apply    = w_boundary && r_pending;

  assign cfg_pending = r_pending;
  assign pwm_out     = r_pwm;
  assign frame_tick  = r_frame_tick;

  // Clamp incoming widths and period before they reach the staging registers
  always_comb begin
    w_period_clamped = (cfg_period_us < PER_MIN) ? PER_MIN : cfg_period_us;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_width_clamped[i] = cfg_width_us[i*CNT_W +: CNT_W];
      if (cfg_width_us[i*CNT_W +: CNT_W] < MIN_W) begin
        w_width_clamped[i] = MIN_W;
      end else if (cfg_width_us[i*CNT_W +: CNT_W] > MAX_W) begin
        w_width_clamped[i] = MAX_W;
      end
    end
  end

  // Slew each channel toward its post-apply target; compare before subtracting
  always_comb begin
    w_step_next = w_apply ? r_step_stg : r_step_act;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_tgt_next[i] = w_apply ? r_width_stg[i] : r_tgt[i];
      w_cur_next[i] = w_tgt_next[i];
      if (w_step_next != '0) begin
        if (w_tgt_next[i] > r_cur[i]) begin
          if ((w_tgt_next[i] - r_cur[i]) > w_step_next) begin
            w_cur_next[i] = r_cur[i] + w_step_next;
          end
        end else if ((r_cur[i] - w_tgt_next[i]) > w_step_next) begin
          w_cur_next[i] = r_cur[i] - w_step_next;
        end
      end
    end
  end

  // Readback of applied widths
  always_comb begin
    cur_width_us = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_width_us[i*CNT_W +: CNT_W] = r_cur[i];
    end
  end

  // Microsecond prescaler, frame counter and frame-start pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_presc      <= '0;
      r_us_cnt     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_us_tick ? '0 : r_presc + PS_W'(1);
      r_frame_tick <= w_boundary;
      if (w_boundary) begin
        r_us_cnt <= '0;
      end else if (w_us_tick) begin
        r_us_cnt <= r_us_cnt + CNT_W'(1);
      end
    end
  end

  // Staging registers; a load coinciding with an apply keeps pending set
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pending    <= 1'b0;
      r_en_stg     <= '0;
      r_period_stg <= DEF_PER;
      r_step_stg   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_width_stg[i] <= DEF_W;
    end else if (cfg_load) begin
      r_pending    <= 1'b1;
      r_en_stg     <= cfg_enable;
      r_period_stg <= w_period_clamped;
      r_step_stg   <= cfg_step_us;
      for (int unsigned i = 0; i < NUM_CH; i++) r_width_stg[i] <= w_width_clamped[i];
    end else if (w_boundary) begin
      r_pending <= 1'b0;
    end
  end

  // Active configuration and slewed widths, updated only at frame boundaries
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_en_act     <= '0;
      r_period_act <= DEF_PER;
      r_step_act   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_tgt[i] <= DEF_W;
        r_cur[i] <= DEF_W;
      end
    end else if (w_boundary) begin
      if (r_pending) begin
        r_en_act     <= r_en_stg;
        r_period_act <= r_period_stg;
      end
      r_step_act <= w_step_next;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_tgt[i] <= w_tgt_next[i];
        r_cur[i] <= w_cur_next[i];
      end
    end
  end

  // Registered PWM compare against the frame counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pwm <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= r_en_act[i] && (r_us_cnt < r_cur[i]);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen. Microsecond quantities are scaled
// down by 10 (MIN 50, MAX 250, DEF 150, default period 2000) with PRESCALE=4
// so every scenario fits in a short run.
module tb_servo_pwm_gen;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PS      = 4;
  localparam int unsigned MIN_US  = 50;
  localparam int unsigned MAX_US  = 250;
  localparam int unsigned DEF_US  = 150;
  localparam int unsigned DEF_PER = 2000;
  localparam int unsigned W       = NUM_CH * CNT_W;
  localparam int          DEF_FRAME = DEF_PER * PS;
  localparam int          LIMIT     = 20000;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              cfg_load = 1'b0;
  logic [NUM_CH-1:0] cfg_enable = '0;
  logic [CNT_W-1:0]  cfg_period_us = '0;
  logic [W-1:0]      cfg_width_us = '0;
  logic [CNT_W-1:0]  cfg_step_us = '0;
  logic              cfg_pending;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_tick;
  logic [W-1:0]      cur_width_us;

  typedef struct packed {
    logic [W-1:0] cur;
    logic         pend;
  } exp_t;

  exp_t exp_q[$];
  int   m_cur[NUM_CH];
  int   n_tests = 0;
  int   n_fail  = 0;

  servo_pwm_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PS), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .DEF_US(DEF_US), .DEF_PERIOD_US(DEF_PER)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_load(cfg_load), .cfg_enable(cfg_enable),
    .cfg_period_us(cfg_period_us), .cfg_width_us(cfg_width_us), .cfg_step_us(cfg_step_us),
    .cfg_pending(cfg_pending), .pwm_out(pwm_out), .frame_tick(frame_tick),
    .cur_width_us(cur_width_us)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
  endfunction

  task automatic step_cyc(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic do_load(input logic [NUM_CH-1:0] en, input int per, input int w0, input int w1,
                         input int w2, input int w3, input int step);
    cfg_enable    = en;
    cfg_period_us = CNT_W'(per);
    cfg_width_us  = pack4(w0, w1, w2, w3);
    cfg_step_us   = CNT_W'(step);
    cfg_load      = 1'b1;
    step_cyc(1);
    cfg_load      = 1'b0;
  endtask

  // Counts cycles to the next frame_tick sample (bounded)
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step_cyc(1);
      n++;
    end while (!frame_tick && n < LIMIT);
  endtask

  // Waits for the DUT to start a frame and pops the matching expectation
  task automatic sb_next(output bit got, output exp_t e);
    int n;
    wait_frame(n);
    got = frame_tick && (exp_q.size() > 0);
    e   = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  // Independent slew model: pushes the expected state after each of nf frames
  task automatic model_push(input int t0, input int t1, input int t2, input int t3,
                            input int step, input int nf);
    int tg[NUM_CH];
    int d;
    tg = '{t0, t1, t2, t3};
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        d = tg[c] - m_cur[c];
        if (step == 0 || (d <= step && -d <= step)) m_cur[c] = tg[c];
        else m_cur[c] = m_cur[c] + ((d > 0) ? step : -step);
      end
      exp_q.push_back('{cur: pack4(m_cur[0], m_cur[1], m_cur[2], m_cur[3]), pend: 1'b0});
    end
  endtask

  task automatic test_reset(input string tag);
    int  n;
    bit  hi;
    ARESETN = 1'b0;
    step_cyc(3);
    @(negedge ACLK);
    ARESETN = 1'b1;
    n_tests++;
    if (cfg_pending !== 1'b0 || frame_tick !== 1'b0 || pwm_out !== '0) begin
      n_fail++;
      $display("FAIL %s reset outputs: pend=%b tick=%b pwm=%b, required 0 0 0000", tag,
               cfg_pending, frame_tick, pwm_out);
    end
    n_tests++;
    if (cur_width_us !== pack4(DEF_US, DEF_US, DEF_US, DEF_US)) begin
      n_fail++;
      $display("FAIL %s reset cur: got %h required %h", tag, cur_width_us,
               pack4(DEF_US, DEF_US, DEF_US, DEF_US));
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      hi = 1'b0;
      do begin
        step_cyc(1);
        n++;
        if (pwm_out !== '0) hi = 1'b1;
      end while (!frame_tick && n < LIMIT);
      n_tests++;
      if (n != DEF_FRAME) begin
        n_fail++;
        $display("FAIL %s frame %0d length: got %0d cycles required %0d", tag, k, n, DEF_FRAME);
      end
      n_tests++;
      if (hi || cfg_pending !== 1'b0 || cur_width_us !== pack4(DEF_US, DEF_US, DEF_US, DEF_US))
      begin
        n_fail++;
        $display("FAIL %s frame %0d state: pwm_seen=%b pend=%b cur=%h, required 0 0 default",
                 tag, k, hi, cfg_pending, cur_width_us);
      end
    end
  endtask

  task automatic test_basic_pwm();
    bit   got;
    exp_t e;
    int   cnt[NUM_CH];
    bit   early;
    do_load(4'b0101, 300, 100, 200, 150, 50, 0);
    n_tests++;
    if (cfg_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL basic pending after load: got %b required 1", cfg_pending);
    end
    repeat (2) exp_q.push_back('{cur: pack4(100, 200, 150, 50), pend: 1'b0});
    for (int k = 0; k < 2; k++) begin
      sb_next(got, e);
      n_tests++;
      if (!got || cur_width_us !== e.cur || cfg_pending !== e.pend) begin
        n_fail++;
        $display("FAIL basic frame %0d: got tick=%b cur=%h pend=%b required cur=%h pend=%b", k,
                 got, cur_width_us, cfg_pending, e.cur, e.pend);
      end
    end
    cnt = '{0, 0, 0, 0};
    early = 1'b0;
    for (int k = 1; k <= 300 * PS; k++) begin
      step_cyc(1);
      for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(pwm_out[c]);
      if (k < 300 * PS && frame_tick) early = 1'b1;
    end
    n_tests++;
    if (early || frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL basic frame length: early=%b tick_at_end=%b required 0 1", early, frame_tick);
    end
    n_tests++;
    if (cnt[0] != 100 * PS || cnt[1] != 0 || cnt[2] != 150 * PS || cnt[3] != 0) begin
      n_fail++;
      $display("FAIL basic high time: got %0d %0d %0d %0d required %0d 0 %0d 0", cnt[0], cnt[1],
               cnt[2], cnt[3], 100 * PS, 150 * PS);
    end
  endtask

  task automatic test_clamp();
    bit   got;
    exp_t e;
    int   n;
    do_load(4'b0101, 0, 10, 300, 250, 50, 0);
    exp_q.push_back('{cur: pack4(MIN_US, MAX_US, MAX_US, MIN_US), pend: 1'b0});
    sb_next(got, e);
    n_tests++;
    if (!got || cur_width_us !== e.cur || cfg_pending !== e.pend) begin
      n_fail++;
      $display("FAIL clamp widths: got tick=%b cur=%h pend=%b required cur=%h pend=%b", got,
               cur_width_us, cfg_pending, e.cur, e.pend);
    end
    wait_frame(n);
    n_tests++;
    if (n != (MAX_US + 1) * PS) begin
      n_fail++;
      $display("FAIL clamp period: got %0d cycles required %0d", n, (MAX_US + 1) * PS);
    end
  endtask

  task automatic test_slew();
    bit   got;
    exp_t e;
    m_cur = '{MIN_US, MAX_US, MAX_US, MIN_US};
    do_load(4'b0000, 0, 150, 150, 150, 150, 0);
    model_push(150, 150, 150, 150, 0, 1);
    sb_next(got, e);
    n_tests++;
    if (!got || cur_width_us !== e.cur) begin
      n_fail++;
      $display("FAIL slew preset: got cur=%h required %h", cur_width_us, e.cur);
    end
    do_load(4'b0000, 0, 200, 200, 100, 150, 20);
    model_push(200, 200, 100, 150, 20, 4);
    for (int k = 0; k < 4; k++) begin
      sb_next(got, e);
      n_tests++;
      if (!got || cur_width_us !== e.cur || cfg_pending !== e.pend) begin
        n_fail++;
        $display("FAIL slew up frame %0d: got cur=%h pend=%b required cur=%h pend=%b", k,
                 cur_width_us, cfg_pending, e.cur, e.pend);
      end
    end
    n_tests++;
    if (cur_width_us !== pack4(200, 200, 100, 150)) begin
      n_fail++;
      $display("FAIL slew up final: got %h required %h", cur_width_us, pack4(200, 200, 100, 150));
    end
    do_load(4'b0000, 0, 100, 100, 200, 150, 20);
    model_push(100, 100, 200, 150, 20, 5);
    for (int k = 0; k < 5; k++) begin
      sb_next(got, e);
      n_tests++;
      if (!got || cur_width_us !== e.cur) begin
        n_fail++;
        $display("FAIL slew down frame %0d: got cur=%h required %h", k, cur_width_us, e.cur);
      end
    end
    n_tests++;
    if (cur_width_us !== pack4(100, 100, 200, 150)) begin
      n_fail++;
      $display("FAIL slew down final: got %h required %h", cur_width_us, pack4(100, 100, 200, 150));
    end
  endtask

  task automatic test_back_to_back();
    bit   got;
    exp_t e;
    int   n;
    localparam int L = (MAX_US + 1) * PS;
    // At a frame start (cycle 0): load A in cycle 0, load B in the boundary cycle L-1
    do_load(4'b0000, 0, 60, 70, 80, 90, 0);
    step_cyc(L - 2);
    do_load(4'b0000, 300, 110, 120, 130, 140, 0);
    n_tests++;
    if (frame_tick !== 1'b1 || cfg_pending !== 1'b1 || cur_width_us !== pack4(60, 70, 80, 90))
    begin
      n_fail++;
      $display("FAIL b2b first apply: tick=%b pend=%b cur=%h required 1 1 %h", frame_tick,
               cfg_pending, cur_width_us, pack4(60, 70, 80, 90));
    end
    exp_q.push_back('{cur: pack4(110, 120, 130, 140), pend: 1'b0});
    sb_next(got, e);
    n_tests++;
    if (!got || cur_width_us !== e.cur || cfg_pending !== e.pend) begin
      n_fail++;
      $display("FAIL b2b second apply: cur=%h pend=%b required cur=%h pend=%b", cur_width_us,
               cfg_pending, e.cur, e.pend);
    end
    wait_frame(n);
    n_tests++;
    if (n != 300 * PS) begin
      n_fail++;
      $display("FAIL b2b period: got %0d cycles required %0d", n, 300 * PS);
    end
    do_load(4'b0000, 0, 60, 60, 60, 60, 0);
    step_cyc(20);
    do_load(4'b0000, 0, 210, 220, 230, 240, 0);
    exp_q.push_back('{cur: pack4(210, 220, 230, 240), pend: 1'b0});
    sb_next(got, e);
    n_tests++;
    if (!got || cur_width_us !== e.cur || cfg_pending !== e.pend) begin
      n_fail++;
      $display("FAIL last write wins: cur=%h pend=%b required cur=%h pend=%b", cur_width_us,
               cfg_pending, e.cur, e.pend);
    end
  endtask

  task automatic test_reset_midframe();
    bit   got;
    exp_t e;
    do_load(4'b1111, 0, 200, 200, 200, 200, 0);
    exp_q.push_back('{cur: pack4(200, 200, 200, 200), pend: 1'b0});
    sb_next(got, e);
    n_tests++;
    if (!got || cur_width_us !== e.cur) begin
      n_fail++;
      $display("FAIL midframe apply: cur=%h required %h", cur_width_us, e.cur);
    end
    step_cyc(5);
    n_tests++;
    if (pwm_out !== 4'hF) begin
      n_fail++;
      $display("FAIL midframe pwm high: got %b required 1111", pwm_out);
    end
    // Stage a config that must be discarded by the reset
    do_load(4'b1111, 300, 60, 60, 60, 60, 5);
    #2;
    ARESETN = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== '0 || cfg_pending !== 1'b0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: pwm=%b pend=%b tick=%b required 0000 0 0", pwm_out,
               cfg_pending, frame_tick);
    end
    n_tests++;
    if (cur_width_us !== pack4(DEF_US, DEF_US, DEF_US, DEF_US)) begin
      n_fail++;
      $display("FAIL async reset cur: got %h required %h", cur_width_us,
               pack4(DEF_US, DEF_US, DEF_US, DEF_US));
    end
    test_reset("post-reset");
  endtask

  initial begin
    test_reset("reset");
    test_basic_pwm();
    test_clamp();
    test_slew();
    test_back_to_back();
    test_reset_midframe();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
